// File: rtl/scalar_rf_pkg.sv
// rtl/scalar_rf_pkg.sv - shared helpers for the scalar register file and its scoreboard
package scalar_rf_pkg;

    // Helpers operate on a wide container; callers zero-extend and truncate to their width.
    localparam int MAX_DW = 128;
    localparam int MAX_NB = MAX_DW / 8;

    function automatic int unsigned cfg_reg_idx(input int unsigned reg_width);
        return (32'd1 << reg_width) - 32'd1;
    endfunction

    function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_v,
                                                     input logic [MAX_DW-1:0] new_v,
                                                     input logic [MAX_NB-1:0] be);
        logic [MAX_DW-1:0] r;
        r = old_v;
        for (int b = 0; b < MAX_NB; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [MAX_DW/2-1:0] vlen_field(input logic [MAX_DW-1:0] v,
                                                       input int unsigned dw);
        logic [MAX_DW/2-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW/2; i++) begin
            if (i < int'(dw/2)) r[i] = v[i];
        end
        return r;
    endfunction

    function automatic logic [MAX_DW/2-1:0] vmask_field(input logic [MAX_DW-1:0] v,
                                                        input int unsigned dw);
        logic [MAX_DW/2-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DW/2; i++) begin
            if (i < int'(dw/2)) r[i] = v[i + int'(dw/2)];
        end
        return r;
    endfunction

endpackage

// File: rtl/scalar_rf_sb_rf_scoreboard.sv
// rtl/scalar_rf_sb_rf_scoreboard.sv - busy vector, outstanding counter, issue-ready logic
module rf_scoreboard
    import scalar_rf_pkg::*;
#(
    parameter int REG_WIDTH = 4,
    localparam int NREG     = 2**REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_i,
    input  logic [REG_WIDTH-1:0] issue_rd_i,
    output logic                 issue_ready_o,
    input  logic                 ret_valid_i,
    input  logic [REG_WIDTH-1:0] ret_rd_i,
    output logic                 ret_ok_o,
    input  logic [REG_WIDTH-1:0] rs1_i,
    input  logic [REG_WIDTH-1:0] rs2_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o,
    output logic [NREG-1:0]      busy_o,
    output logic [REG_WIDTH:0]   outstanding_o
);

    logic [NREG-1:0]    busy_q, busy_d;
    logic [REG_WIDTH:0] outstanding_q, outstanding_d;
    logic               set_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            outstanding_q <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_comb begin
        issue_ready_o = (issue_rd_i == '0) | ~busy_q[issue_rd_i]
                      | (ret_valid_i & (ret_rd_i == issue_rd_i));
        // busy[0] is never set, so this also rejects returns to r0
        ret_ok_o      = ret_valid_i & busy_q[ret_rd_i];
        set_en        = issue_i & issue_ready_o & (issue_rd_i != '0);

        busy_d = busy_q;
        if (ret_ok_o) busy_d[ret_rd_i] = 1'b0;
        if (set_en)   busy_d[issue_rd_i] = 1'b1;

        outstanding_d = outstanding_q + (REG_WIDTH+1)'(set_en) - (REG_WIDTH+1)'(ret_ok_o);

        rs1_busy_o = busy_q[rs1_i] & ~(ret_valid_i & (ret_rd_i == rs1_i));
        rs2_busy_o = busy_q[rs2_i] & ~(ret_valid_i & (ret_rd_i == rs2_i));
    end

    assign busy_o        = busy_q;
    assign outstanding_o = outstanding_q;

endmodule

// File: rtl/scalar_rf_sb.sv
// rtl/scalar_rf_sb.sv - scalar register file with scoreboard, byte-enable writes and bypass
module scalar_rf_sb
    import scalar_rf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4,
    localparam int NBYTE     = DATA_WIDTH / 8,
    localparam int NREG      = 2**REG_WIDTH,
    localparam int HALF      = DATA_WIDTH / 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_WIDTH-1:0]  rs1_i,
    input  logic [REG_WIDTH-1:0]  rs2_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    input  logic                  wen_i,
    input  logic [REG_WIDTH-1:0]  rd_i,
    input  logic [NBYTE-1:0]      rd_be_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  lq_issue_i,
    input  logic [REG_WIDTH-1:0]  lq_issue_rd_i,
    output logic                  lq_issue_ready_o,
    input  logic                  lq_valid_i,
    input  logic [REG_WIDTH-1:0]  lq_rd_i,
    input  logic [DATA_WIDTH-1:0] lq_data_i,
    output logic [HALF-1:0]       vlen_o,
    output logic [HALF-1:0]       vmask_o,
    output logic                  cfg_update_o,
    output logic [REG_WIDTH:0]    outstanding_o,
    output logic                  hazard_o
);

    localparam logic [REG_WIDTH-1:0] CFG = REG_WIDTH'(cfg_reg_idx(REG_WIDTH));

    logic [DATA_WIDTH-1:0] rf_q [NREG];
    logic [DATA_WIDTH-1:0] rf_d [NREG];
    logic [DATA_WIDTH-1:0] alu_merged;
    logic [NREG-1:0]       busy;
    logic                  ret_ok, alu_ok, alu_waw;
    logic                  cfg_update_q, cfg_update_d;
    logic                  hazard_q, hazard_d;

    rf_scoreboard #(.REG_WIDTH(REG_WIDTH)) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_i       (lq_issue_i),
        .issue_rd_i    (lq_issue_rd_i),
        .issue_ready_o (lq_issue_ready_o),
        .ret_valid_i   (lq_valid_i),
        .ret_rd_i      (lq_rd_i),
        .ret_ok_o      (ret_ok),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .rs1_busy_o    (rs1_busy_o),
        .rs2_busy_o    (rs2_busy_o),
        .busy_o        (busy),
        .outstanding_o (outstanding_o)
    );

    // Forwarded values match exactly what the register will hold after this edge.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REG_WIDTH-1:0] rs);
        if (rs == '0)                        return '0;
        else if (ret_ok && (lq_rd_i == rs))  return lq_data_i;
        else if (alu_ok && (rd_i == rs))     return alu_merged;
        else                                 return rf_q[rs];
    endfunction

    always_comb begin
        alu_merged = DATA_WIDTH'(byte_merge(MAX_DW'(rf_q[rd_i]), MAX_DW'(rd_data_i),
                                            MAX_NB'(rd_be_i)));
        alu_waw    = wen_i & (rd_i != '0) & busy[rd_i];
        alu_ok     = wen_i & (rd_i != '0) & ~busy[rd_i];

        rf_d = rf_q;
        if (alu_ok) rf_d[rd_i] = alu_merged;
        if (ret_ok) rf_d[lq_rd_i] = lq_data_i;

        cfg_update_d = (alu_ok & (rd_i == CFG) & (|rd_be_i)) | (ret_ok & (lq_rd_i == CFG));
        hazard_d     = alu_waw | (lq_valid_i & ~ret_ok);

        rs1_data_o = read_port(rs1_i);
        rs2_data_o = read_port(rs2_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            cfg_update_q <= 1'b0;
            hazard_q     <= 1'b0;
        end else begin
            rf_q         <= rf_d;
            cfg_update_q <= cfg_update_d;
            hazard_q     <= hazard_d;
        end
    end

    assign vlen_o       = HALF'(vlen_field(MAX_DW'(rf_q[CFG]), DATA_WIDTH));
    assign vmask_o      = HALF'(vmask_field(MAX_DW'(rf_q[CFG]), DATA_WIDTH));
    assign cfg_update_o = cfg_update_q;
    assign hazard_o     = hazard_q;

endmodule

// File: tb/tb_scalar_rf_sb.sv
// tb/tb_scalar_rf_sb.sv - scoreboard-checked directed bench for scalar_rf_sb
module tb_scalar_rf_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rs1_i, rs2_i;
    logic [15:0] rs1_data_o, rs2_data_o;
    logic        rs1_busy_o, rs2_busy_o;
    logic        wen_i;
    logic [3:0]  rd_i;
    logic [1:0]  rd_be_i;
    logic [15:0] rd_data_i;
    logic        lq_issue_i;
    logic [3:0]  lq_issue_rd_i;
    logic        lq_issue_ready_o;
    logic        lq_valid_i;
    logic [3:0]  lq_rd_i;
    logic [15:0] lq_data_i;
    logic [7:0]  vlen_o, vmask_o;
    logic        cfg_update_o;
    logic [4:0]  outstanding_o;
    logic        hazard_o;

    scalar_rf_sb #(.DATA_WIDTH(16), .REG_WIDTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rs1_i            (rs1_i),
        .rs2_i            (rs2_i),
        .rs1_data_o       (rs1_data_o),
        .rs2_data_o       (rs2_data_o),
        .rs1_busy_o       (rs1_busy_o),
        .rs2_busy_o       (rs2_busy_o),
        .wen_i            (wen_i),
        .rd_i             (rd_i),
        .rd_be_i          (rd_be_i),
        .rd_data_i        (rd_data_i),
        .lq_issue_i       (lq_issue_i),
        .lq_issue_rd_i    (lq_issue_rd_i),
        .lq_issue_ready_o (lq_issue_ready_o),
        .lq_valid_i       (lq_valid_i),
        .lq_rd_i          (lq_rd_i),
        .lq_data_i        (lq_data_i),
        .vlen_o           (vlen_o),
        .vmask_o          (vmask_o),
        .cfg_update_o     (cfg_update_o),
        .outstanding_o    (outstanding_o),
        .hazard_o         (hazard_o)
    );

    always #5 clk = ~clk;

    localparam int S_RS1D = 0, S_RS2D = 1, S_RS1B = 2, S_RS2B = 3, S_RDY = 4,
                   S_OUT = 5, S_VLEN = 6, S_VMASK = 7, S_CFGU = 8, S_HAZ = 9;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t keep[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] get_sig(input int s);
        case (s)
            S_RS1D:  return rs1_data_o;
            S_RS2D:  return rs2_data_o;
            S_RS1B:  return {15'b0, rs1_busy_o};
            S_RS2B:  return {15'b0, rs2_busy_o};
            S_RDY:   return {15'b0, lq_issue_ready_o};
            S_OUT:   return {11'b0, outstanding_o};
            S_VLEN:  return {8'b0, vlen_o};
            S_VMASK: return {8'b0, vmask_o};
            S_CFGU:  return {15'b0, cfg_update_o};
            default: return {15'b0, hazard_o};
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle, away from the edge.
    always @(negedge clk) begin
        logic [15:0] got;
        keep = {};
        foreach (q[i]) begin
            if (q[i].cyc == cyc) begin
                got = get_sig(q[i].sig);
                checks = checks + 1;
                if (got !== q[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", q[i].name, cyc, got, q[i].val);
                end
            end else if (q[i].cyc < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL %s stale expectation for cyc=%0d", q[i].name, q[i].cyc);
            end else begin
                keep.push_back(q[i]);
            end
        end
        q = keep;
    end

    task automatic ex(input int dc, input int s, input logic [15:0] v, input string n);
        exp_t e;
        e.cyc = cyc + dc; e.sig = s; e.val = v; e.name = n;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wen_i = 0; rd_i = 0; rd_be_i = 0; rd_data_i = 0;
        lq_issue_i = 0; lq_issue_rd_i = 0; lq_valid_i = 0; lq_rd_i = 0; lq_data_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; rs1_i = 0; rs2_i = 0;
        step();
        step();
        rst_n = 1;
        ex(0, S_OUT, 0, "reset_outstanding");
        ex(0, S_VLEN, 0, "reset_vlen");
        ex(0, S_VMASK, 0, "reset_vmask");
        ex(0, S_HAZ, 0, "reset_hazard");
        ex(0, S_CFGU, 0, "reset_cfg_update");
        for (int i = 0; i < 16; i++) begin
            step();
            rs1_i = 4'(i); rs2_i = 4'(15 - i);
            ex(0, S_RS1D, 0, "reset_read_rs1");
            ex(0, S_RS2D, 0, "reset_read_rs2");
        end

        // Byte-enable writes to r3 with same-cycle bypass
        step(); wen_i = 1; rd_i = 3; rd_be_i = 2'b01; rd_data_i = 16'hABCD; rs1_i = 3;
        ex(0, S_RS1D, 16'h00CD, "be01_bypass");
        step(); wen_i = 1; rd_i = 3; rd_be_i = 2'b10; rd_data_i = 16'h12FF; rs1_i = 3; rs2_i = 3;
        ex(0, S_RS1D, 16'h12CD, "be10_bypass_rs1");
        ex(0, S_RS2D, 16'h12CD, "be10_bypass_rs2");
        step(); rs1_i = 3;
        ex(0, S_RS1D, 16'h12CD, "r3_stored");

        // Issue to r5
        step(); lq_issue_i = 1; lq_issue_rd_i = 5; rs1_i = 5;
        ex(0, S_RDY, 1, "issue_r5_ready");
        ex(0, S_RS1B, 0, "r5_not_busy_yet");
        step(); lq_issue_i = 1; lq_issue_rd_i = 5; rs1_i = 5;
        ex(0, S_RS1B, 1, "r5_busy");
        ex(0, S_OUT, 1, "outstanding_1");
        ex(0, S_RDY, 0, "reissue_r5_not_ready");
        step(); lq_issue_i = 1; lq_issue_rd_i = 5; lq_valid_i = 1; lq_rd_i = 5;
        lq_data_i = 16'h1234; rs1_i = 5;
        ex(0, S_RDY, 1, "reissue_with_return_ready");
        ex(0, S_RS1D, 16'h1234, "return_bypass_1234");
        ex(0, S_RS1B, 0, "return_forward_not_busy");
        step(); lq_valid_i = 1; lq_rd_i = 5; lq_data_i = 16'h55AA; rs1_i = 5;
        ex(0, S_OUT, 1, "outstanding_held_1");
        ex(0, S_RS1D, 16'h55AA, "return_bypass_55aa");
        ex(0, S_RS1B, 0, "return_55aa_not_busy");
        ex(0, S_HAZ, 0, "no_hazard_on_set_clear");
        step(); rs1_i = 5;
        ex(0, S_OUT, 0, "outstanding_0");
        ex(0, S_RS1D, 16'h55AA, "r5_stored");

        // WAW hazard, then return to idle register
        step(); lq_issue_i = 1; lq_issue_rd_i = 5;
        ex(0, S_RDY, 1, "issue_r5_again");
        step(); wen_i = 1; rd_i = 5; rd_be_i = 2'b11; rd_data_i = 16'hDEAD; rs1_i = 5;
        ex(0, S_RS1B, 1, "r5_busy_waw");
        ex(0, S_RS1D, 16'h55AA, "waw_not_bypassed");
        step(); rs1_i = 5;
        ex(0, S_HAZ, 1, "waw_hazard");
        ex(0, S_RS1D, 16'h55AA, "waw_dropped");
        step(); lq_valid_i = 1; lq_rd_i = 6; lq_data_i = 16'h6666;
        ex(0, S_HAZ, 0, "waw_hazard_one_cycle");
        step(); rs2_i = 6;
        ex(0, S_HAZ, 1, "idle_return_hazard");
        ex(0, S_RS2D, 0, "idle_return_dropped");
        ex(0, S_OUT, 1, "outstanding_still_1");

        // ALU and return to the same register: return wins
        step(); wen_i = 1; rd_i = 5; rd_be_i = 2'b11; rd_data_i = 16'h1111;
        lq_valid_i = 1; lq_rd_i = 5; lq_data_i = 16'h7777; rs1_i = 5;
        ex(0, S_HAZ, 0, "idle_hazard_one_cycle");
        ex(0, S_RS1D, 16'h7777, "return_wins_bypass");
        step(); wen_i = 1; rd_i = 0; rd_be_i = 2'b11; rd_data_i = 16'hFFFF; rs1_i = 5; rs2_i = 0;
        ex(0, S_HAZ, 1, "alu_ret_collision_hazard");
        ex(0, S_RS1D, 16'h7777, "return_wins_stored");
        ex(0, S_OUT, 0, "outstanding_after_collision");
        ex(0, S_RS2D, 0, "r0_write_bypass_zero");
        step(); lq_issue_i = 1; lq_issue_rd_i = 0; rs2_i = 0;
        ex(0, S_RS2D, 0, "r0_stays_zero");
        ex(0, S_RDY, 1, "issue_r0_ready");
        step();
        ex(0, S_OUT, 0, "issue_r0_not_counted");

        // Config register
        step(); wen_i = 1; rd_i = 15; rd_be_i = 2'b11; rd_data_i = 16'hF010;
        ex(0, S_VLEN, 0, "vlen_not_bypassed");
        ex(0, S_CFGU, 0, "cfg_update_not_yet");
        step();
        ex(0, S_VLEN, 16'h0010, "vlen_updated");
        ex(0, S_VMASK, 16'h00F0, "vmask_updated");
        ex(0, S_CFGU, 1, "cfg_update_pulse");
        step(); lq_issue_i = 1; lq_issue_rd_i = 7;
        ex(0, S_CFGU, 0, "cfg_update_one_cycle");
        step(); rs1_i = 7; rs2_i = 15;
        ex(0, S_OUT, 1, "r7_outstanding");
        ex(0, S_RS1B, 1, "r7_busy");

        // Asynchronous reset with r7 outstanding
        step(); rst_n = 0; rs1_i = 7; rs2_i = 15;
        ex(0, S_OUT, 0, "reset_clears_outstanding");
        ex(0, S_RS1B, 0, "reset_clears_busy");
        ex(0, S_VLEN, 0, "reset_clears_vlen");
        ex(0, S_RS2D, 0, "reset_clears_r15");
        step(); rst_n = 1; lq_valid_i = 1; lq_rd_i = 7; lq_data_i = 16'h7070; rs1_i = 7;
        ex(0, S_HAZ, 0, "hazard_low_after_reset");
        step(); rs1_i = 7;
        ex(0, S_HAZ, 1, "post_reset_return_hazard");
        ex(0, S_RS1D, 0, "post_reset_return_dropped");
        ex(0, S_OUT, 0, "post_reset_outstanding");
        step();
        ex(0, S_HAZ, 0, "post_reset_hazard_one_cycle");

        step();
        step();
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL leftover_expectations got=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_rf_sb.md
# scalar_rf_sb

Parametrised scalar register file with per-register scoreboard, byte-enable writes, write-to-read bypass and a vector-config register. It replaces the two-mode scalar RF in the NPU scalar path. It serves the decode/issue stage with two read ports, a single-cycle ALU write port and a long-latency (load/DMA) return port. Busy tracking lets issue stall on RAW/WAW hazards against outstanding long-latency results.

## Interface
- DATA_WIDTH, 16, register width; multiple of 8, ≥16
- REG_WIDTH, 4, register index width; NREG = 2**REG_WIDTH
- NBYTE, DATA_WIDTH/8, byte lanes per register (derived, not overridable)
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- rs1_i, rs2_i  in  REG_WIDTH  read indices
- rs1_data_o, rs2_data_o  out  DATA_WIDTH  read data; r0 reads 0
- rs1_busy_o, rs2_busy_o  out  1  source has an outstanding long-latency result
- wen_i  in  1  ALU write strobe
- rd_i  in  REG_WIDTH  ALU write index
- rd_be_i  in  NBYTE  ALU byte enables; all-ones is a full write
- rd_data_i  in  DATA_WIDTH  ALU write data
- lq_issue_i  in  1  long-latency op issued targeting lq_issue_rd_i
- lq_issue_rd_i  in  REG_WIDTH  destination of issued op
- lq_issue_ready_o  out  1  issue accepted this cycle
- lq_valid_i  in  1  long-latency result returning (full-width write)
- lq_rd_i  in  REG_WIDTH  return destination
- lq_data_i  in  DATA_WIDTH  return data
- vlen_o  out  DATA_WIDTH/2  low half of r[NREG-1]
- vmask_o  out  DATA_WIDTH/2  high half of r[NREG-1]
- cfg_update_o  out  1  one-cycle pulse after any write lands in r[NREG-1]
- outstanding_o  out  REG_WIDTH+1  count of busy registers
- hazard_o  out  1  one-cycle pulse: protocol violation (see Operation)

## Operation
- r0 is hardwired to 0. Writes to r0 are dropped, and r0 is never busy.
- ALU write: each lane b with rd_be_i[b]=1 updates r[rd_i][8b+7:8b]. Other lanes hold.
- ALU write to a busy register (WAW) is dropped and pulses hazard_o.
- Return write: full-width write to r[lq_rd_i] and clears busy[lq_rd_i].
- Return to a non-busy register is dropped and pulses hazard_o.
- ALU and return to the same register in one cycle: the return wins and hazard_o pulses, because the ALU write to a busy register is illegal.
- Issue: lq_issue_ready_o = (lq_issue_rd_i==0) | ~busy[lq_issue_rd_i] | (lq_valid_i & lq_rd_i==lq_issue_rd_i).
- On issue & ready, busy[lq_issue_rd_i] is set (r0 excepted). Set has priority over a same-cycle clear.
- Issue while not ready: no state change and no hazard. The issuer must hold and retry.
- Reads with bypass. Priority is r0 → return-port match → ALU-port match (byte-merged with stored value) → stored value.
- rsX_busy_o = busy[rsX] & ~(lq_valid_i & lq_rd_i==rsX). A same-cycle return is forwarded and therefore not busy.
- outstanding_o = popcount(busy). It is maintained incrementally: +1 on accepted issue (rd≠0), −1 on accepted return, net 0 when both occur.

## Timing
- Reads, busy, ready: combinational from current state plus the same-cycle write ports. Zero-latency bypass.
- Writes and busy changes are visible in state at the next posedge.
- vlen_o/vmask_o update the cycle after the write. They are not bypassed.
- cfg_update_o and hazard_o are registered and assert in the cycle following the causing event.
- Reset (any time, including with outstanding results): all registers 0, busy 0, outstanding_o 0, cfg_update_o 0, hazard_o 0.
- A return arriving after reset deassertion for a pre-reset issue is treated as a return to a non-busy register: dropped, hazard_o pulses.

## Structure
- Shared package scalar_rf_pkg holds:
  - CFG_REG index function (NREG-1)
  - byte-merge function (old, new, be)
  - vlen/vmask field slicing
- One sub-module, rf_scoreboard, holds the busy vector, the outstanding counter, and the ready/busy logic.
- The data array, bypass muxes and cfg/hazard registers stay in the top.

## Test plan
- Reset, then read all registers → 0; outstanding_o=0; vlen_o=vmask_o=0.
- ALU write r3=0xABCD with be=2'b01 → r3=0x00CD. Then be=2'b10 with 0x12FF → r3=0x12CD. Same-cycle read of r3 during the second write returns 0x12CD.
- Issue to r5 → rs1_busy_o=1 for rs1=5, outstanding_o=1.
  - Return 0x55AA to r5 → same-cycle rs1_data_o=0x55AA with busy=0. Next cycle outstanding_o=0.
- With r5 busy, issue to r5 → ready=0.
  - Issue again while the return to r5 is in the same cycle → ready=1; busy stays 1 and outstanding_o stays 1.
- ALU write to busy r5 → r5 unchanged, hazard_o=1 for one cycle. Return to idle r6 → dropped, hazard_o pulse.
- Write r15=0xF010 → next cycle vlen_o=0x10, vmask_o=0xF0, cfg_update_o=1 for one cycle.
  - Assert rst_n low with r7 busy → outstanding_o=0. A post-reset return to r7 → hazard_o pulse.
